// File: rtl/cnt_responder.sv
// cnt_responder: board-side responder for the 4-phase counter-read handshake.
// Holds NUM_CNT 64-bit event counters. Each request returns one 32-bit word.
// A low-word read snapshots the high word so that a following high read of the
// same counter yields a coherent 64-bit value.
//
// Ports:
//   coreclk    block clock
//   corerstn   asynchronous active-low reset
//   cnt_req    4-phase request, may be asynchronous to coreclk (synchronized here)
//   cnt_addr   byte address, held stable for the whole handshake
//   cnt_data   read word, valid while cnt_ack=1
//   cnt_ack    acknowledge
//   cnt_event  per-counter increment enable (coreclk domain)
//   cnt_clear  synchronous clear of all counters and the shadow

// One counter lane: clear wins over increment, wraps naturally at 2^64.
module cnt_responder_lane (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        inc,
    output logic [63:0] value
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     value <= '0;
        else if (clear) value <= '0;
        else if (inc)   value <= value + 64'd1;
    end
endmodule

module cnt_responder #(
    parameter int NUM_CNT     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               coreclk,
    input  logic               corerstn,
    input  logic               cnt_req,
    input  logic [31:0]        cnt_addr,
    output logic [31:0]        cnt_data,
    output logic               cnt_ack,
    input  logic [NUM_CNT-1:0] cnt_event,
    input  logic               cnt_clear
);
    localparam int IDX_W = $clog2(NUM_CNT);

    typedef enum logic [1:0] {IDLE, LOOKUP, ACK} state_t;

    state_t                    state, state_next;
    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      req_s;
    logic [NUM_CNT-1:0][63:0]  cnt_val;
    logic [31:0]               shadow_hi;
    logic [IDX_W-1:0]          shadow_idx;
    logic                      shadow_valid;

    logic [IDX_W-1:0]          idx;
    logic                      hi_sel;
    logic                      mapped;
    logic [63:0]               sel_val;
    logic [31:0]               rd_word;

    // Request synchronizer; address needs none since it is stable while req is high.
    always_ff @(posedge coreclk or negedge corerstn) begin
        if (!corerstn) sync_q <= '0;
        else           sync_q <= {sync_q[SYNC_STAGES-2:0], cnt_req};
    end
    assign req_s = sync_q[SYNC_STAGES-1];

    genvar g;
    generate
        for (g = 0; g < NUM_CNT; g++) begin : g_lane
            cnt_responder_lane u_lane (
                .clk   (coreclk),
                .rst_n (corerstn),
                .clear (cnt_clear),
                .inc   (cnt_event[g]),
                .value (cnt_val[g])
            );
        end
    endgenerate

    // Address decode: [2] word select, [3 +: IDX_W] counter, everything else zero.
    assign idx     = cnt_addr[3 +: IDX_W];
    assign hi_sel  = cnt_addr[2];
    assign mapped  = (cnt_addr[1:0] == 2'b00) && ((cnt_addr >> (3 + IDX_W)) == 32'd0);
    assign sel_val = cnt_val[idx];

    always_comb begin
        rd_word = '0;
        if (mapped) begin
            if (!hi_sel)                                 rd_word = sel_val[31:0];
            else if (shadow_valid && shadow_idx == idx)  rd_word = shadow_hi;
            else                                         rd_word = sel_val[63:32];
        end
    end

    // FSM
    always_ff @(posedge coreclk or negedge corerstn) begin
        if (!corerstn) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_s) state_next = LOOKUP;
            LOOKUP:  state_next = ACK;
            ACK:     if (!req_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ack is a pure state decode, so an asynchronous reset drops it at once.
    assign cnt_ack = (state == ACK);

    // Read data and shadow are both updated on the LOOKUP edge; clear overrides
    // any shadow capture happening on the same edge.
    always_ff @(posedge coreclk or negedge corerstn) begin
        if (!corerstn) begin
            cnt_data     <= '0;
            shadow_hi    <= '0;
            shadow_idx   <= '0;
            shadow_valid <= 1'b0;
        end else begin
            if (state == LOOKUP) cnt_data <= rd_word;
            if (cnt_clear) begin
                shadow_valid <= 1'b0;
            end else if (state == LOOKUP && mapped) begin
                if (!hi_sel) begin
                    shadow_hi    <= sel_val[63:32];
                    shadow_idx   <= idx;
                    shadow_valid <= 1'b1;
                end else begin
                    shadow_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cnt_responder.sv
// tb_cnt_responder: directed checks of latency, shadow coherence, unmapped
// reads, wrap/clear and reset behaviour, followed by randomly timed requests
// checked against a reference counter/shadow model.
module tb_cnt_responder;
    logic        coreclk;
    logic        corerstn;
    logic        cnt_req;
    logic [31:0] cnt_addr;
    logic [31:0] cnt_data;
    logic        cnt_ack;
    logic [7:0]  cnt_event;
    logic        cnt_clear;

    int total = 0;
    int bad   = 0;
    logic allow_noreq = 1'b0;

    cnt_responder #(.NUM_CNT(8), .SYNC_STAGES(2)) dut (
        .coreclk   (coreclk),
        .corerstn  (corerstn),
        .cnt_req   (cnt_req),
        .cnt_addr  (cnt_addr),
        .cnt_data  (cnt_data),
        .cnt_ack   (cnt_ack),
        .cnt_event (cnt_event),
        .cnt_clear (cnt_clear)
    );

    initial coreclk = 1'b0;
    always #5 coreclk = ~coreclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ack must only rise while a request is present (except the deliberate violation test).
    always @(posedge cnt_ack) begin
        if (!allow_noreq) chk("ack_without_req", {63'd0, cnt_req}, 64'd1);
    end

    // Directed read with cycle-exact latency checks on both ack edges.
    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge coreclk);
        cnt_addr = a;
        cnt_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge coreclk);
            chk({tag, "_ack_rise"}, {63'd0, cnt_ack}, (i == 3) ? 64'd1 : 64'd0);
        end
        chk({tag, "_data"}, {32'd0, cnt_data}, {32'd0, exp});
        cnt_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge coreclk);
            chk({tag, "_ack_fall"}, {63'd0, cnt_ack}, (i < 2) ? 64'd1 : 64'd0);
        end
    endtask

    task automatic pulse_events(input logic [7:0] ev, input int n);
        @(negedge coreclk);
        cnt_event = ev;
        repeat (n) @(negedge coreclk);
        cnt_event = '0;
    endtask

    logic [63:0] model [8];
    logic [31:0] sh_hi;
    int          sh_idx;
    logic        sh_v;

    initial begin
        logic [31:0] a, exp, held;
        int k, n;
        logic hi, unm, got, clr;
        logic [7:0] ev;

        corerstn  = 1'b0;
        cnt_req   = 1'b0;
        cnt_addr  = '0;
        cnt_event = '0;
        cnt_clear = 1'b0;
        repeat (2) @(negedge coreclk);
        chk("rst_ack", {63'd0, cnt_ack}, 64'd0);
        chk("rst_data", {32'd0, cnt_data}, 64'd0);
        corerstn = 1'b1;
        repeat (2) @(negedge coreclk);
        chk("idle_ack", {63'd0, cnt_ack}, 64'd0);

        // Counter 3 counted 5 times.
        pulse_events(8'h08, 5);
        rd("c3_lo", 32'h18, 32'd5);
        rd("c3_hi", 32'h1C, 32'd0);

        // Counter 1 preloaded to 2^32 + 0xFFFFFFFE; shadow must keep high word.
        @(negedge coreclk);
        force dut.g_lane[1].u_lane.value = 64'h0000_0001_FFFF_FFFE;
        @(negedge coreclk);
        release dut.g_lane[1].u_lane.value;
        rd("c1_lo", 32'h08, 32'hFFFF_FFFE);
        pulse_events(8'h02, 3);
        rd("c1_hi_shadow", 32'h0C, 32'h0000_0001);
        rd("c1_hi_live", 32'h0C, 32'h0000_0002);
        rd("c1_lo2", 32'h08, 32'h0000_0001);

        // Unmapped addresses.
        rd("unm_40", 32'h40, 32'h0);
        rd("unm_09", 32'h09, 32'h0);

        // 64-bit wrap on counter 5.
        @(negedge coreclk);
        force dut.g_lane[5].u_lane.value = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge coreclk);
        release dut.g_lane[5].u_lane.value;
        pulse_events(8'h20, 1);
        rd("wrap_lo", 32'h28, 32'h0);
        rd("wrap_hi", 32'h2C, 32'h0);

        // Clear with simultaneous event: counter zero and shadow dropped.
        @(negedge coreclk);
        force dut.g_lane[2].u_lane.value = 64'h0000_0007_0000_0004;
        @(negedge coreclk);
        release dut.g_lane[2].u_lane.value;
        rd("c2_lo", 32'h10, 32'h4);
        @(negedge coreclk);
        cnt_event = 8'h04;
        cnt_clear = 1'b1;
        @(negedge coreclk);
        cnt_event = '0;
        cnt_clear = 1'b0;
        rd("clr_hi", 32'h14, 32'h0);
        rd("clr_lo", 32'h10, 32'h0);

        // Reset during ACK, then a still-held request is serviced afresh.
        pulse_events(8'h08, 2);
        @(negedge coreclk);
        cnt_addr = 32'h18;
        cnt_req  = 1'b1;
        repeat (4) @(negedge coreclk);
        chk("rack_ack", {63'd0, cnt_ack}, 64'd1);
        chk("rack_data", {32'd0, cnt_data}, 64'd2);
        #2 corerstn = 1'b0;
        #1;
        chk("rack_async_drop", {63'd0, cnt_ack}, 64'd0);
        chk("rack_data_rst", {32'd0, cnt_data}, 64'd0);
        @(negedge coreclk);
        corerstn = 1'b1;
        repeat (3) @(negedge coreclk);
        chk("refresh_wait", {63'd0, cnt_ack}, 64'd0);
        @(negedge coreclk);
        chk("refresh_ack", {63'd0, cnt_ack}, 64'd1);
        chk("refresh_data", {32'd0, cnt_data}, 64'd0);
        cnt_req = 1'b0;
        repeat (3) @(negedge coreclk);
        chk("refresh_fall", {63'd0, cnt_ack}, 64'd0);

        // Req withdrawn early: one-cycle ack pulse.
        allow_noreq = 1'b1;
        @(negedge coreclk);
        cnt_addr = 32'h08;
        cnt_req  = 1'b1;
        @(negedge coreclk);
        cnt_req  = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge coreclk);
            chk("viol_pulse", {63'd0, cnt_ack}, (i == 3) ? 64'd1 : 64'd0);
        end
        allow_noreq = 1'b0;

        // Randomly timed transactions against a reference model.
        corerstn = 1'b0;
        @(negedge coreclk);
        corerstn = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = '0;
        sh_v = 1'b0; sh_hi = '0; sh_idx = 0;
        for (int t = 0; t < 1000; t++) begin
            n = $urandom_range(0, 4);
            repeat (n) begin
                @(negedge coreclk);
                ev  = 8'($urandom);
                clr = ($urandom_range(0, 19) == 0);
                cnt_event = ev;
                cnt_clear = clr;
                if (clr) begin
                    for (int i = 0; i < 8; i++) model[i] = '0;
                    sh_v = 1'b0;
                end else begin
                    for (int i = 0; i < 8; i++) if (ev[i]) model[i] = model[i] + 64'd1;
                end
            end
            @(negedge coreclk);
            cnt_event = '0;
            cnt_clear = 1'b0;

            k   = $urandom_range(0, 7);
            hi  = 1'($urandom_range(0, 1));
            unm = ($urandom_range(0, 7) == 0);
            a   = (32'(k) << 3) | (32'(hi) << 2);
            if (unm) begin
                case ($urandom_range(0, 2))
                    0:       a = a | 32'h1;
                    1:       a = a | 32'h2;
                    default: a = a | (32'h40 << $urandom_range(0, 25));
                endcase
                exp = '0;
            end else if (!hi) begin
                exp    = model[k][31:0];
                sh_hi  = model[k][63:32];
                sh_idx = k;
                sh_v   = 1'b1;
            end else begin
                exp  = (sh_v && sh_idx == k) ? sh_hi : model[k][63:32];
                sh_v = 1'b0;
            end

            cnt_addr = a;
            #($urandom_range(1, 4));
            cnt_req = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge coreclk);
                got = cnt_ack;
            end
            chk("rnd_ack_rise", {63'd0, got}, 64'd1);
            held = cnt_data;
            chk("rnd_data", {32'd0, held}, {32'd0, exp});
            repeat ($urandom_range(0, 3)) begin
                @(negedge coreclk);
                chk("rnd_data_stable", {31'd0, cnt_ack, cnt_data}, {31'd0, 1'b1, held});
            end
            #($urandom_range(1, 4));
            cnt_req = 1'b0;
            got = 1'b1;
            for (int c = 0; c < 20 && got; c++) begin
                @(negedge coreclk);
                got = cnt_ack;
            end
            chk("rnd_ack_fall", {63'd0, got}, 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
